serial_w_transmitter: RTL and testbench

- Serial stimulus source for the Mealy sequence-detector datapath. Accepts a parallel frame over a valid/ready handshake and drives it one bit per clock onto the serial input `w` of the detector's input combinational logic.
- It is the transmitting end of the `w` interface that the detector's input logic consumes.
- Used both in system-level benches and as an on-chip pattern source.

---
 rtl/serial_w_transmitter.sv | 114 +++++++++++
 tb/tb_serial_w_transmitter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_w_transmitter.sv
// Parallel-to-serial source for the detector input w: accepts a frame over
// valid/ready and shifts it out MSB-first, one bit per clock.
module serial_w_transmitter #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             abort,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;
    logic             accept;

    // Length clamp and left alignment of the offered frame.
    always_comb begin
        if ((load_len == {LEN_W{1'b0}}) || (load_len > LEN_W'(WIDTH))) begin
            eff_len = LEN_W'(WIDTH);
        end else begin
            eff_len = load_len;
        end
        aligned = load_data << (LEN_W'(WIDTH) - eff_len);
    end

    // Ready in IDLE or on the last-bit cycle so frames can run back to back.
    always_comb begin
        case (state)
            IDLE:    load_ready = 1'b1;
            SEND:    load_ready = (count == LEN_W'(1));
            default: load_ready = 1'b0;
        endcase
        accept = load_valid & load_ready & ~abort;
    end

    // Transmit FSM; w/w_valid/busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= {WIDTH{1'b0}};
            count   <= {LEN_W{1'b0}};
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            shreg   <= {WIDTH{1'b0}};
            count   <= {LEN_W{1'b0}};
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (accept) begin
            // done is set only when this load replaces a finishing frame
            state   <= SEND;
            shreg   <= aligned;
            count   <= eff_len;
            w       <= aligned[WIDTH-1];
            w_valid <= 1'b1;
            busy    <= 1'b1;
            done    <= (state == SEND);
        end else begin
            case (state)
                IDLE: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                SEND: begin
                    shreg <= shreg << 1;
                    count <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        state   <= IDLE;
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        w       <= shreg[WIDTH-2];
                        w_valid <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_w_transmitter.sv
// Directed bench for serial_w_transmitter: inputs change and outputs are
// sampled on the falling edge; cycle k is the half period after rising edge k.
module tb_serial_w_transmitter;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic [3:0] load_len;
    logic       abort;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_w_transmitter #(.WIDTH(8), .LEN_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .abort      (abort),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one frame, then check n bits (exp_bits[n-1] first), the done pulse and IDLE.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic [3:0] len,
                             input int n, input logic [7:0] exp_bits);
        load_data  = data;
        load_len   = len;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_wv%0d", tag, i), {31'd0, w_valid}, 32'd1);
            check_eq($sformatf("%s_w%0d", tag, i), {31'd0, w}, {31'd0, exp_bits[n-1-i]});
            check_eq($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            check_eq($sformatf("%s_rdy%0d", tag, i), {31'd0, load_ready}, (i == n-1) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s_dn%0d", tag, i), {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_wv_end"}, {31'd0, w_valid}, 32'd0);
        check_eq({tag, "_w_end"}, {31'd0, w}, 32'd0);
        check_eq({tag, "_rdy_end"}, {31'd0, load_ready}, 32'd1);
        @(negedge clk);
        check_eq({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    endtask

    logic [9:0] b2b_bits;

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_len   = 4'd0;
        abort      = 1'b0;
        #1;
        check_eq("rst_w", {31'd0, w}, 32'd0);
        check_eq("rst_wv", {31'd0, w_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_rdy", {31'd0, load_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_frame("full", 8'hB5, 4'd8, 8, 8'hB5);
        run_frame("short", 8'hFE, 4'd3, 3, 8'h06);
        run_frame("len0", 8'h0F, 4'd0, 8, 8'h0F);
        run_frame("len12", 8'h0F, 4'd12, 8, 8'h0F);

        // Back-to-back: second frame held valid from cycle 1, taken at the last-bit edge.
        b2b_bits   = 10'b1011010111;
        load_data  = 8'hB5;
        load_len   = 4'd8;
        load_valid = 1'b1;
        @(negedge clk);
        load_data = 8'h03;
        load_len  = 4'd2;
        for (int c = 1; c <= 11; c++) begin
            check_eq($sformatf("b2b_wv%0d", c), {31'd0, w_valid}, (c <= 10) ? 32'd1 : 32'd0);
            if (c <= 10) begin
                check_eq($sformatf("b2b_w%0d", c), {31'd0, w}, {31'd0, b2b_bits[10-c]});
            end
            check_eq($sformatf("b2b_dn%0d", c), {31'd0, done}, (c == 9 || c == 11) ? 32'd1 : 32'd0);
            if (c == 9) begin
                load_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("b2b_idle", {31'd0, busy}, 32'd0);

        // Abort after three bits of 8'hB5.
        load_data  = 8'hB5;
        load_len   = 4'd8;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        check_eq("ab_b0", {31'd0, w}, 32'd1);
        @(negedge clk);
        check_eq("ab_b1", {31'd0, w}, 32'd0);
        @(negedge clk);
        check_eq("ab_b2", {31'd0, w}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("ab_wv", {31'd0, w_valid}, 32'd0);
        check_eq("ab_busy", {31'd0, busy}, 32'd0);
        check_eq("ab_rdy", {31'd0, load_ready}, 32'd1);
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("ab_nodone%0d", c), {31'd0, done}, 32'd0);
            check_eq($sformatf("ab_quiet%0d", c), {31'd0, w_valid}, 32'd0);
            @(negedge clk);
        end

        // Abort together with a load in IDLE blocks the load.
        load_data  = 8'hFF;
        load_len   = 4'd4;
        load_valid = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        abort      = 1'b0;
        check_eq("abld_wv", {31'd0, w_valid}, 32'd0);
        check_eq("abld_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("abld_wv2", {31'd0, w_valid}, 32'd0);

        // Reset mid-frame takes effect immediately and suppresses done.
        load_data  = 8'hFF;
        load_len   = 4'd8;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        check_eq("mr_pre_wv", {31'd0, w_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mr_w", {31'd0, w}, 32'd0);
        check_eq("mr_wv", {31'd0, w_valid}, 32'd0);
        check_eq("mr_busy", {31'd0, busy}, 32'd0);
        check_eq("mr_done", {31'd0, done}, 32'd0);
        check_eq("mr_rdy", {31'd0, load_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("mr_after%0d", c), {30'd0, w_valid, done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
